// File: rtl/ecc_pkg.sv
// Shared widths, codeword field layout and FSM state type for the ECC write arbiter.
package ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CW_W   = 39;
  localparam int unsigned PAR_W  = 7;

  // Codeword layout: data in the low bits, parity P32..P38 above it.
  localparam int unsigned CW_DATA_LSB = 0;
  localparam int unsigned CW_DATA_MSB = 31;
  localparam int unsigned CW_PAR_LSB  = 32;
  localparam int unsigned CW_PAR_MSB  = 38;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] cw_data(input logic [CW_W-1:0] cw);
    return cw[CW_DATA_MSB:CW_DATA_LSB];
  endfunction

  function automatic logic [PAR_W-1:0] cw_parity(input logic [CW_W-1:0] cw);
    return cw[CW_PAR_MSB:CW_PAR_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning from rr_ptr upward, wrapping.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  always_comb begin : pick
    int unsigned      idx;
    logic [IDX_W-1:0] pos;
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      pos = IDX_W'(idx);
      if (!any_req && req[pos]) begin
        any_req     = 1'b1;
        grant[pos]  = 1'b1;
        winner      = pos;
      end
    end
  end

endmodule

// File: rtl/ecc_wr_arbiter.sv
// Round-robin arbiter sharing one external SECDED encoder and one SRAM write port among requesters.
module ecc_wr_arbiter
  import ecc_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned ADDR_W  = 10,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]     req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [31:0]               enc_data_out,
  input  logic [38:0]               enc_codeword_in,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [38:0]               mem_wdata,
  input  logic                      mem_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      enc_err,
  output logic [CNT_W-1:0]          wr_count
);

  state_t              state, next_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]   data_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CW_W-1:0]     cw_reg;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_winner;
  logic                arb_any;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [ID_W-1:0]     ptr_next;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_winner == ID_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*32 +: 32];
      end
    end
  end

  assign ptr_next = (arb_winner == ID_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (arb_any)   next_state = ENC;
      ENC:                    next_state = WR;
      WR:      if (mem_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      data_reg <= '0;
      addr_reg <= '0;
      cw_reg   <= '0;
      grant_id <= '0;
      enc_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            addr_reg <= win_addr;
            data_reg <= win_data;
            grant_id <= arb_winner;
            rr_ptr   <= ptr_next;
          end
        end
        ENC: begin
          cw_reg <= enc_codeword_in;
          if (cw_data(enc_codeword_in) != data_reg) enc_err <= 1'b1;
        end
        WR: begin
          if (mem_ready && wr_count != '1) wr_count <= wr_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes are gated by rst so nothing handshakes or writes while reset is held.
  always_comb begin
    req_ready = '0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      if (state == IDLE) req_ready = arb_grant;
      mem_we = (state == WR);
      busy   = (state != IDLE);
    end
  end

  assign enc_data_out = data_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = cw_reg;

endmodule

// File: tb/tb_ecc_wr_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle plus directed literal checks.
module tb_ecc_wr_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*32-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [31:0]     enc_data_out;
  logic [38:0]     enc_codeword_in;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [38:0]     mem_wdata;
  logic            mem_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            enc_err;
  logic [CW-1:0]   wr_count;
  logic            force_bad;

  int vectors = 0;
  int errors  = 0;
  logic [NR-1:0] rdy_seen = '0;

  always #5 clk = ~clk;

  ecc_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .enc_data_out(enc_data_out), .enc_codeword_in(enc_codeword_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy), .enc_err(enc_err), .wr_count(wr_count)
  );

  // Linear parity stand-in for the external encoder; column for data bit 0 is 7'h41.
  function automatic logic [6:0] par(input logic [31:0] d);
    logic [6:0] p = '0;
    for (int i = 0; i < 32; i++)
      if (d[i]) p = p ^ 7'(((i + 1) * 65) & 127);
    return p;
  endfunction

  function automatic logic [38:0] code(input logic [31:0] d, input logic bad);
    return {par(d), bad ? 32'hFFFF_FFFF : d};
  endfunction

  assign enc_codeword_in = code(enc_data_out, force_bad);

  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++)
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one optional in-flight transaction, tagged with whether it has been encoded yet.
  bit          started = 0;
  bit          m_active, m_encoded, m_err;
  int          m_ptr, m_gid, m_cnt;
  logic [AW-1:0] m_addr;
  logic [31:0] m_data;
  logic [38:0] m_cw;

  always @(negedge clk) begin : compare
    logic [NR-1:0] e_ready;
    int w;
    w = pick(req_valid, m_ptr);
    e_ready = (!rst && !m_active && w >= 0) ? NR'(1 << w) : '0;
    if (started) begin
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("mem_we", 64'(mem_we), 64'(!rst && m_active && m_encoded));
      chk("busy", 64'(busy), 64'(!rst && m_active));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("enc_data_out", 64'(enc_data_out), 64'(m_data));
      chk("enc_err", 64'(enc_err), 64'(m_err));
      chk("wr_count", 64'(wr_count), 64'(m_cnt));
      if (!rst && m_active && m_encoded) begin
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_cw));
      end
    end
    rdy_seen = req_ready;
    if (rst) begin
      m_active = 0; m_encoded = 0; m_err = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
      m_addr = '0; m_data = '0; m_cw = '0;
      started = 1;
    end else if (!m_active) begin
      if (w >= 0) begin
        m_gid = w;
        m_addr = req_addr[w*AW +: AW];
        m_data = req_data[w*32 +: 32];
        m_ptr = (w + 1) % NR;
        m_active = 1;
        m_encoded = 0;
      end
    end else if (!m_encoded) begin
      m_cw = code(m_data, force_bad);
      if (force_bad && m_data != 32'hFFFF_FFFF) m_err = 1;
      m_encoded = 1;
    end else if (mem_ready) begin
      m_active = 0;
      if (m_cnt != (1 << CW) - 1) m_cnt++;
    end
  end

  // Clients drop valid on the edge that completes their handshake.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy_seen;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; mem_ready = 1'b1; force_bad = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("t0_reset_count", 64'(wr_count), 64'd0);
    chk("t0_reset_we", 64'(mem_we), 64'd0);

    // Single request, requester 0.
    set_req(0, 10'h005, 32'h0000_0001);
    req_valid = 4'b0001;
    #1 chk("t1_ready", 64'(req_ready), 64'h1);
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_we_enc", 64'(mem_we), 64'd0);
    step();
    chk("t1_we", 64'(mem_we), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h005);
    chk("t1_wdata", 64'(mem_wdata), 64'h41_0000_0001);
    step();
    chk("t1_count", 64'(wr_count), 64'd1);
    chk("t1_we_done", 64'(mem_we), 64'd0);

    // All four valid from reset.
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, AW'(10'h100 + i), 32'hA000_0000 + i);
    req_valid = 4'b1111;
    #1 chk("t2_ready_in_rst", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    for (int g = 0; g < NR; g++) begin
      #1 chk("t2_grant", 64'(req_ready), 64'(1 << g));
      step();
      chk("t2_grant_id", 64'(grant_id), 64'(g));
      step();
      step();
    end
    chk("t2_count", 64'(wr_count), 64'd4);

    // Round-robin: after serving 2, requesters 1 and 3 compete.
    set_req(2, 10'h222, 32'h2222_2222);
    req_valid = 4'b0100;
    repeat (3) step();
    set_req(1, 10'h011, 32'h1111_1111);
    set_req(3, 10'h033, 32'h3333_3333);
    req_valid = 4'b1010;
    #1 chk("t3_first", 64'(req_ready), 64'b1000);
    repeat (3) step();
    chk("t3_second", 64'(req_ready), 64'b0010);
    repeat (3) step();
    chk("t3_sat", 64'(wr_count), 64'd7);

    // Backpressure with requester 1 waiting; count stays saturated.
    mem_ready = 1'b0;
    set_req(0, 10'h3FF, 32'hDEAD_BEEF);
    req_valid = 4'b0001;
    step();
    req_valid = req_valid | 4'b0010;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t4_we", 64'(mem_we), 64'd1);
      chk("t4_addr", 64'(mem_addr), 64'h3FF);
      chk("t4_wdata", 64'(mem_wdata), 64'(code(32'hDEAD_BEEF, 1'b0)));
      chk("t4_noready", 64'(req_ready), 64'd0);
      step();
    end
    mem_ready = 1'b1;
    #1 chk("t4_we_release", 64'(mem_we), 64'd1);
    step();
    chk("t4_we_off", 64'(mem_we), 64'd0);
    chk("t4_next", 64'(req_ready), 64'b0010);
    repeat (3) step();
    chk("t4_sat", 64'(wr_count), 64'd7);

    // Reset while writing; rr_ptr must restart at 0.
    set_req(2, 10'h111, 32'h1234_5678);
    req_valid = 4'b0100;
    step();
    step();
    chk("t5_we_pre", 64'(mem_we), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_we", 64'(mem_we), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_count", 64'(wr_count), 64'd0);
    req_valid = 4'b1010;
    #1 chk("t5_ptr0", 64'(req_ready), 64'b0010);
    repeat (3) step();
    chk("t5_then3", 64'(req_ready), 64'b1000);
    repeat (3) step();
    chk("t5_count2", 64'(wr_count), 64'd2);

    // Encoder fault on zero data.
    set_req(0, 10'h02A, 32'h0);
    req_valid = 4'b0001;
    step();
    force_bad = 1'b1;
    #1 chk("t6_err_pre", 64'(enc_err), 64'd0);
    step();
    force_bad = 1'b0;
    chk("t6_err", 64'(enc_err), 64'd1);
    chk("t6_wdata", 64'(mem_wdata), 64'h00_FFFF_FFFF);
    step();
    chk("t6_count", 64'(wr_count), 64'd3);
    req_valid = 4'b0001;
    repeat (3) step();
    chk("t6_sticky", 64'(enc_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_cleared", 64'(enc_err), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ecc_wr_arbiter.md
Name: ecc_wr_arbiter

Overview:
- Shares one external 32->39 SECDED encoder and one memory write port among NUM_REQ write requesters.
- Arbitrates round-robin, registers the winner's address and data, and drives the data into the encoder.
- Captures the 39-bit codeword and holds the memory write until the memory accepts it.
- Sits between the client write paths and the ECC-protected SRAM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, memory word address width.
- CNT_W, 16, width of the saturating write counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*32  packed data; requester i at [i*32 +: 32].
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational from state and req_valid.
- enc_data_out  out  32  data to encoder.
- enc_codeword_in  in  39  encoder result; [31:0] data, [38:32] parity P32..P38.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  39  codeword to write.
- mem_ready  in  1  memory accepts the write this cycle when mem_we=1.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently in service.
- busy  out  1  high in ENC or WR.
- enc_err  out  1  sticky; set when enc_codeword_in[31:0] != data_reg during ENC.
- wr_count  out  CNT_W  completed writes; saturates at all-ones.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, rr_ptr=0, data_reg=0, addr_reg=0, cw_reg=0, grant_id=0, enc_err=0, wr_count=0.
  - Outputs during and after reset: mem_we=0, req_ready=0, busy=0, enc_data_out=0.
- FSM states: IDLE, ENC, WR.
- IDLE:
  - If any req_valid, the winner is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle, so the handshake completes this cycle.
  - At the edge: latch addr_reg/data_reg from the winner, grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, go to ENC.
  - If no req_valid, stay in IDLE.
- req_ready is all-zero in ENC and WR; requesters hold valid until granted.
- enc_data_out = data_reg at all times (registered, glitch-free).
- ENC (exactly 1 cycle):
  - At the edge: cw_reg <= enc_codeword_in; if enc_codeword_in[31:0] != data_reg, set enc_err; go to WR.
- WR:
  - mem_we=1, mem_addr=addr_reg, mem_wdata=cw_reg, held stable until mem_ready=1.
  - On mem_we&mem_ready: wr_count increments (saturating), go to IDLE.
- Latency: grant at cycle N, mem_we first high at N+2. Minimum 3 cycles per write; no overlap between consecutive writes.
- Simultaneous requests: only one grant per IDLE cycle; the others wait.
- A requester dropping req_valid before it is granted is legal and not serviced.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation (ENC or WR):
  - The transaction is abandoned and mem_we=0 the following cycle.
  - A request already handshaked is lost; the client re-issues it.
- enc_err clears only on rst.
- wr_count holds at 2^CNT_W-1 once saturated.

Decomposition:
- Package ecc_pkg holds:
  - DATA_W=32, CW_W=39, PAR_W=7.
  - The state enum {IDLE, ENC, WR}.
  - Codeword field ranges: data [31:0], parity [38:32].
- Sub-module rr_arbiter (parameter N) holds the round-robin pick logic.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_req.
- The encoder stays external and is wired in at the top level.

Test Plan:
- Single request: req_valid[0] with addr 0x005, data 0x00000001, encoder attached.
  -> req_ready[0] pulse in cycle N; mem_we at N+2 with mem_addr=0x005, mem_wdata=0x4100000001; wr_count=1.
- All four requesters valid from reset, mem_ready=1.
  -> grants in order 0,1,2,3 at 3-cycle spacing; grant_id follows; wr_count=4.
- Round-robin after grant to requester 2, then req_valid[1] and req_valid[3] both high.
  -> 3 is served before 1.
- Backpressure: mem_ready=0 for 5 cycles in WR.
  -> mem_we, mem_addr, mem_wdata stable all 5 cycles; write completes on the cycle mem_ready=1; no req_ready meanwhile.
- Reset in WR: rst asserted while mem_we=1.
  -> next cycle mem_we=0, busy=0, wr_count=0, rr_ptr=0; a following req_valid[1] is granted normally.
- Encoder fault: force enc_codeword_in[31:0] to 0xFFFFFFFF while data_reg=0x0.
  -> enc_err=1 after the ENC edge and stays set until rst; the write still completes with the forced codeword.
